// File: rtl/neo_pkg.sv
// Shared types for the NeoPixel frame producer: pattern modes, GRB channel
// order and the producer FSM states.
package neo_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    COLOR_G = 2'd0,
    COLOR_R = 2'd1,
    COLOR_B = 2'd2
  } color_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_TX,
    ST_GAP
  } state_t;

  localparam int NUM_COLORS = 3;
  localparam int FRAME_W    = 8;

endpackage

// File: rtl/counter.sv
// Library up-counter: synchronous clear, increment enable, wraps to zero
// after MAX. o_wrap flags the incrementing cycle that performs the wrap.
module counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_wrap  = i_inc && (r_count == MAX);
  assign o_count = r_count;

  // NOTE: state is updated only with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || o_wrap) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/neo_level_gen.sv
// Combinational pattern generator: colour level for one (pixel, channel)
// slot given the latched mode/base and the current frame number.
module neo_level_gen
  import neo_pkg::*;
#(
  parameter  int LEVEL_W    = 8,
  parameter  int NUM_PIXELS = 5,
  parameter  int PIX_STEP   = 32,
  parameter  int COLOR_STEP = 85,
  localparam int PIX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  mode_t              i_mode,
  input  logic [LEVEL_W-1:0] i_base,
  input  logic [PIX_W-1:0]   i_pixel,
  input  logic [1:0]         i_color,
  input  logic [FRAME_W-1:0] i_frame,
  output logic [LEVEL_W-1:0] o_level
);

  localparam logic [31:0] NP_U    = 32'(NUM_PIXELS);
  localparam logic [31:0] PSTEP_U = 32'(PIX_STEP);
  localparam logic [31:0] CSTEP_U = 32'(COLOR_STEP);

  logic [31:0] w_ramp;
  logic        w_chase_hit;

  assign w_chase_hit = (32'(i_pixel) == (32'(i_frame) % NP_U));
  // Wide sum, then truncation to LEVEL_W gives the modulo wrap for free.
  assign w_ramp = 32'(i_frame) + 32'(i_pixel) * PSTEP_U + 32'(i_color) * CSTEP_U;

  // NOTE: o_level gets a default first so no path through the case leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    o_level = '0;
    case (i_mode)
      MODE_SOLID: o_level = i_base;
      MODE_CHASE: o_level = w_chase_hit ? i_base : '0;
      MODE_RAMP:  o_level = w_ramp[LEVEL_W-1:0];
      default:    o_level = '0;
    endcase
  end

endmodule

// File: rtl/register.sv
// Library load-enable register with asynchronous clear.
module register #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/neo_frame_producer.sv
// Frame producer for the NeoPixel driver: streams GRB levels for every pixel,
// requests a send, waits out the transmission and an inter-frame gap.
module neo_frame_producer
  import neo_pkg::*;
#(
  parameter  int NUM_PIXELS = 5,
  parameter  int LEVEL_W    = 8,
  parameter  int FRAME_GAP  = 1000,
  parameter  int PIX_STEP   = 32,
  parameter  int COLOR_STEP = 85,
  localparam int PIX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [LEVEL_W-1:0] base_level,
  input  logic               ready_to_load,
  input  logic               ready_to_send,
  output logic [PIX_W-1:0]   pixel_index,
  output logic [1:0]         color_index,
  output logic [LEVEL_W-1:0] color_level,
  output logic               load_color,
  output logic               send_it,
  output logic [7:0]         frame_count,
  output logic               busy
);

  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  state_t r_state;

  logic [PIX_W-1:0]   w_pixel;
  logic [1:0]         w_color;
  logic [GAP_W-1:0]   w_gap_count;
  logic [FRAME_W-1:0] w_frame;
  logic [1:0]         w_mode_q;
  logic [LEVEL_W-1:0] w_base_q;
  logic [LEVEL_W-1:0] w_level;
  logic               w_tx_seen;
  logic               w_load_fire;
  logic               w_send_fire;
  logic               w_color_wrap;
  logic               w_last_slot;
  logic               w_gap_last;
  logic               w_frame_wrap;
  logic               w_latch;
  logic               w_unused;

  assign w_load_fire = (r_state == ST_LOAD) && ready_to_load;
  assign w_send_fire = (r_state == ST_SEND) && ready_to_send;
  assign w_latch     = enable && ((r_state == ST_IDLE) || w_gap_last);
  assign w_unused    = &{1'b0, w_frame_wrap, w_gap_count};

  counter #(.W(2), .MAX(2'(NUM_COLORS - 1))) u_color_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_clear (r_state != ST_LOAD),
    .i_inc   (w_load_fire),
    .o_count (w_color),
    .o_wrap  (w_color_wrap)
  );

  // The pixel counter wraps exactly on the load of the final slot.
  counter #(.W(PIX_W), .MAX(PIX_W'(NUM_PIXELS - 1))) u_pixel_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_clear (r_state != ST_LOAD),
    .i_inc   (w_color_wrap),
    .o_count (w_pixel),
    .o_wrap  (w_last_slot)
  );

  counter #(.W(GAP_W), .MAX(GAP_W'(FRAME_GAP - 1))) u_gap_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_clear (r_state != ST_GAP),
    .i_inc   (r_state == ST_GAP),
    .o_count (w_gap_count),
    .o_wrap  (w_gap_last)
  );

  counter #(.W(FRAME_W), .MAX('1)) u_frame_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_clear (1'b0),
    .i_inc   (w_gap_last),
    .o_count (w_frame),
    .o_wrap  (w_frame_wrap)
  );

  register #(.W(2)) u_mode_reg (
    .clock (clock),
    .reset (reset),
    .i_en  (w_latch),
    .i_d   (mode),
    .o_q   (w_mode_q)
  );

  register #(.W(LEVEL_W)) u_base_reg (
    .clock (clock),
    .reset (reset),
    .i_en  (w_latch),
    .i_d   (base_level),
    .o_q   (w_base_q)
  );

  // Cleared while sending; set by the driver's first not-ready cycle after.
  register #(.W(1)) u_tx_seen_reg (
    .clock (clock),
    .reset (reset),
    .i_en  ((r_state == ST_SEND) || ((r_state == ST_WAIT_TX) && !ready_to_load)),
    .i_d   (r_state == ST_WAIT_TX),
    .o_q   (w_tx_seen)
  );

  neo_level_gen #(
    .LEVEL_W    (LEVEL_W),
    .NUM_PIXELS (NUM_PIXELS),
    .PIX_STEP   (PIX_STEP),
    .COLOR_STEP (COLOR_STEP)
  ) u_level_gen (
    .i_mode  (mode_t'(w_mode_q)),
    .i_base  (w_base_q),
    .i_pixel (w_pixel),
    .i_color (w_color),
    .i_frame (w_frame),
    .o_level (w_level)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (enable) r_state <= ST_LOAD;
        ST_LOAD:    if (w_last_slot) r_state <= ST_SEND;
        ST_SEND:    if (ready_to_send) r_state <= ST_WAIT_TX;
        ST_WAIT_TX: if (w_tx_seen && ready_to_load) r_state <= ST_GAP;
        ST_GAP:     if (w_gap_last) r_state <= enable ? ST_LOAD : ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign load_color  = w_load_fire;
  assign send_it     = w_send_fire;
  assign pixel_index = w_load_fire ? w_pixel : '0;
  assign color_index = w_load_fire ? w_color : '0;
  assign color_level = w_load_fire ? w_level : '0;
  assign frame_count = w_frame;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_neo_frame_producer.sv
// Self-checking bench for neo_frame_producer: randomized handshakes checked
// against a slot-by-slot reference model of the frame protocol.
module tb_neo_frame_producer;

  localparam int NP      = 5;
  localparam int LW      = 8;
  localparam int GAP     = 4;
  localparam int NSLOTS  = 3 * NP;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [1:0]    mode;
  logic [LW-1:0] base_level;
  logic          ready_to_load;
  logic          ready_to_send;
  logic [2:0]    pixel_index;
  logic [1:0]    color_index;
  logic [LW-1:0] color_level;
  logic          load_color;
  logic          send_it;
  logic [7:0]    frame_count;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int model_fc = 0;

  neo_frame_producer #(
    .NUM_PIXELS (NP),
    .LEVEL_W    (LW),
    .FRAME_GAP  (GAP),
    .PIX_STEP   (32),
    .COLOR_STEP (85)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .base_level    (base_level),
    .ready_to_load (ready_to_load),
    .ready_to_send (ready_to_send),
    .pixel_index   (pixel_index),
    .color_index   (color_index),
    .color_level   (color_level),
    .load_color    (load_color),
    .send_it       (send_it),
    .frame_count   (frame_count),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference pattern: level for slot (p, c) in frame f.
  function automatic logic [7:0] ref_level(input int m, input int b, input int p,
                                           input int c, input int f);
    case (m)
      1:       return 8'(b);
      2:       return (p == (f % NP)) ? 8'(b) : 8'd0;
      3:       return 8'((f + p * 32 + c * 85) % 256);
      default: return 8'd0;
    endcase
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_load"}, load_color, 0);
    check({tag, "_send"}, send_it, 0);
    check({tag, "_pix"}, pixel_index, 0);
    check({tag, "_col"}, color_index, 0);
    check({tag, "_lvl"}, color_level, 0);
  endtask

  // Leaves the DUT in IDLE, one tick after a rising edge, enable low.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_fc = 0;
    check_quiet("rst_now");
    check("rst_now_fc", frame_count, 0);
    check("rst_now_busy", busy, 0);
    enable = 1'b1;
    ready_to_load = 1'b1;
    ready_to_send = 1'b1;
    @(posedge clock); #1;
    check_quiet("rst_held");
    check("rst_held_busy", busy, 0);
    enable = 1'b0;
    ready_to_load = 1'b0;
    ready_to_send = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  // From IDLE: raise enable and move into the first LOAD cycle.
  task automatic start_frame(input int m, input int b);
    enable = 1'b1;
    mode = 2'(m);
    base_level = 8'(b);
    ready_to_load = 1'b1;
    #2;
    check("idle_load", load_color, 0);
    check("idle_busy", busy, 0);
    @(posedge clock); #1;
    check("start_busy", busy, 1);
  endtask

  // pat: 0 ready held high, 1 toggling, 2 random. abort: 1 reset after three
  // loads, 2 reset in the second gap cycle.
  task automatic do_frame(input int m, input int b, input int nm, input int nb,
                          input int pat, input int drop_at, input int abort);
    int  k;
    int  cyc;
    int  f;
    int  n1;
    int  n0;
    bit  rl;
    bit  rs;
    bit  done;
    f = model_fc;
    k = 0;
    cyc = 0;
    while (k < NSLOTS && cyc < 200) begin
      case (pat)
        0:       rl = 1'b1;
        1:       rl = (cyc % 2 == 0);
        default: rl = 1'($urandom_range(0, 1));
      endcase
      rs = 1'($urandom_range(0, 1));
      ready_to_load = rl;
      ready_to_send = rs;
      @(negedge clock);
      check("ld_strobe", load_color, 32'(rl));
      check("ld_nosend", send_it, 0);
      if (rl) begin
        check("ld_pix", pixel_index, k / 3);
        check("ld_col", color_index, k % 3);
        check("ld_lvl", color_level, ref_level(m, b, k / 3, k % 3, f));
        k++;
      end else begin
        check("stall_lvl", color_level, 0);
      end
      if (k == 1) begin
        mode = 2'($urandom);
        base_level = 8'($urandom);
      end
      if (k == drop_at) enable = 1'b0;
      @(posedge clock); #1;
      cyc++;
      if (abort == 1 && k == 3) begin
        do_reset();
        return;
      end
    end
    check("ld_count", k, NSLOTS);

    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin
      rs = (cyc >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
      ready_to_send = rs;
      ready_to_load = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("snd_strobe", send_it, 32'(rs));
      check("snd_noload", load_color, 0);
      check("snd_busy", busy, 1);
      done = rs;
      @(posedge clock); #1;
      cyc++;
    end
    check("snd_seen", done, 1);
    ready_to_send = 1'b0;

    n1 = $urandom_range(0, 2);
    n0 = $urandom_range(1, 3);
    for (int i = 0; i < n1 + n0 + 1; i++) begin
      ready_to_load = (i < n1) ? 1'b1 : (i < n1 + n0) ? 1'b0 : 1'b1;
      ready_to_send = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("tx_load", load_color, 0);
      check("tx_send", send_it, 0);
      check("tx_fc", frame_count, f);
      @(posedge clock); #1;
    end

    for (int g = 0; g < GAP; g++) begin
      ready_to_load = 1'($urandom_range(0, 1));
      ready_to_send = 1'($urandom_range(0, 1));
      if (g == 0) begin
        mode = 2'(nm);
        base_level = 8'(nb);
      end
      @(negedge clock);
      check("gap_busy", busy, 1);
      check("gap_fc", frame_count, f);
      check("gap_load", load_color, 0);
      check("gap_send", send_it, 0);
      if (abort == 2 && g == 1) begin
        do_reset();
        return;
      end
      @(posedge clock); #1;
    end
    model_fc = (f + 1) % 256;
    check("end_fc", frame_count, model_fc);
    check("end_busy", busy, 32'(enable));
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    mode = 2'd0;
    base_level = '0;
    ready_to_load = 1'b0;
    ready_to_send = 1'b0;
    #1;
    do_reset();

    // RAMP frames 0 and 1, then SOLID 0x20 with ready held high.
    start_frame(3, 0);
    do_frame(3, 0, 3, 0, 0, -1, 0);
    do_frame(3, 0, 1, 8'h20, 2, -1, 0);
    do_frame(1, 8'h20, 2, 8'h10, 0, -1, 0);
    // Six CHASE frames: the lit pixel walks through every position and wraps.
    for (int i = 0; i < 6; i++) do_frame(2, 8'h10, 2, 8'h10, 2, -1, 0);
    // Toggling ready, then an enable drop after three loads.
    do_frame(2, 8'h10, 1, 8'h55, 1, -1, 0);
    do_frame(1, 8'h55, 1, 8'h55, 0, 3, 0);

    for (int i = 0; i < 5; i++) begin
      ready_to_load = 1'($urandom_range(0, 1));
      ready_to_send = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("idle_busy", busy, 0);
      check_quiet("idle");
      @(posedge clock); #1;
    end

    // Reset mid-LOAD, then mid-GAP, then a clean CHASE frame from zero.
    start_frame(1, 8'hA5);
    do_frame(1, 8'hA5, 1, 8'hA5, 2, -1, 1);
    start_frame(3, 0);
    do_frame(3, 0, 3, 0, 2, -1, 2);
    start_frame(2, 8'h7F);
    do_frame(2, 8'h7F, 2, 8'h7F, 2, NSLOTS, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neo_frame_producer.md
# neo_frame_producer

- Parametrised frame producer for the NeoPixel driver.
- Streams one color level per (pixel, color) slot for `NUM_PIXELS` pixels in GRB order, then requests a send.
- Waits for the driver to finish the transmission, holds an inter-frame gap, and advances a frame counter that animates the selected pattern mode.
- Sits between the board-level control inputs and the NeoPixel driver's load/send handshake.

## Interface
Parameters:
- `NUM_PIXELS`, 5: pixels per strip, ≥1.
- `LEVEL_W`, 8: color level width, ≥8.
- `FRAME_GAP`, 1000: idle cycles between end of transmission and next frame, ≥1.
- `PIX_STEP`, 32: RAMP level offset per pixel.
- `COLOR_STEP`, 85: RAMP level offset per color channel.

Ports (`PIX_W = max(1, $clog2(NUM_PIXELS))`):
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: run frames while high.
- `mode` in 2: 0 OFF, 1 SOLID, 2 CHASE, 3 RAMP.
- `base_level` in LEVEL_W: brightness for SOLID and CHASE.
- `ready_to_load` in 1: driver accepts a load this cycle.
- `ready_to_send` in 1: driver accepts a send this cycle.
- `pixel_index` out PIX_W: pixel being loaded.
- `color_index` out 2: 0 G, 1 R, 2 B.
- `color_level` out LEVEL_W: level being loaded.
- `load_color` out 1: load strobe.
- `send_it` out 1: send strobe.
- `frame_count` out 8: completed frames, wraps 255→0.
- `busy` out 1: high in any state except IDLE.

## Operation
FSM states: IDLE, LOAD, SEND, WAIT_TX, GAP.

- **IDLE**
  - When `enable`=1: latch `mode` and `base_level`, clear slot counters, go to LOAD.
- **LOAD**
  - Slot order: pixel 0..NUM_PIXELS-1 (outer), color 0..2 (inner).
  - A load fires in any cycle with `ready_to_load`=1.
  - On a firing cycle: `load_color`=1, with `pixel_index`, `color_index` and `color_level` presenting the current slot. The slot then advances.
  - `ready_to_load`=0 stalls with no load and no advance.
  - The cycle after the load of slot (NUM_PIXELS-1, 2), go to SEND.
- **SEND**
  - Fires in the first cycle with `ready_to_send`=1: `send_it`=1 for exactly that cycle, then go to WAIT_TX.
  - `ready_to_load` is ignored in this state.
- **WAIT_TX**
  - First requires one cycle with `ready_to_load`=0 (the `tx_seen` flag).
  - Then, on the first cycle with `ready_to_load`=1, go to GAP.
- **GAP**
  - Count `FRAME_GAP` cycles.
  - On the last gap cycle, `frame_count` increments.
  - Next state: LOAD if `enable`=1, relatching `mode` and `base_level`; otherwise IDLE.
- Outputs `load_color`, `send_it`, `pixel_index`, `color_index` and `color_level` are 0 whenever no strobe is active.

Level function (slot p, c; latched mode m, latched base b; f = `frame_count` zero-extended to LEVEL_W):
- OFF: 0.
- SOLID: b.
- CHASE: b if p == f mod NUM_PIXELS, else 0.
- RAMP: (f + p·PIX_STEP + c·COLOR_STEP) mod 2^LEVEL_W, truncating.

Boundary rules:
- `mode` and `base_level` changes mid-frame have no effect until the next frame latch.
- `enable` falling mid-frame: the frame completes through GAP, then IDLE. `frame_count` still increments.
- NUM_PIXELS=1: slots (0,0), (0,1), (0,2) only. CHASE lights pixel 0 every frame.
- `ready_to_load` and `ready_to_send` both high in LOAD: only the load fires.
- Reset at any point: state IDLE, all counters and `frame_count` 0, all outputs 0 while reset is asserted.

## Timing
- Strobe outputs are combinational from state, slot counters and the ready inputs; they are valid in the same cycle as the ready.
- Minimum frame: 3·NUM_PIXELS load cycles, + 1 SEND, + ≥2 WAIT_TX, + FRAME_GAP cycles.
- IDLE→first load: 1 cycle after `enable` is seen high.
- `frame_count` updates on the clock edge ending the last GAP cycle.
- Reset values: `load_color`=0, `send_it`=0, `pixel_index`=0, `color_index`=0, `color_level`=0, `frame_count`=0, `busy`=0.

## Structure
- Shared package `neo_pkg`:
  - `mode_t` enum (OFF, SOLID, CHASE, RAMP).
  - `color_t` enum (G=0, R=1, B=2).
  - FSM state enum.
- Slot, gap and frame counters reuse the existing `counter` library module.
- Latched mode/base and `tx_seen` reuse `register`.
- Sub-module `neo_level_gen`: combinational level function, parametrised by LEVEL_W, NUM_PIXELS, PIX_STEP and COLOR_STEP.

## Test plan
All cases use NUM_PIXELS=5, FRAME_GAP=4, LEVEL_W=8.
- SOLID, base 0x20, `ready_to_load` held high → 15 consecutive loads, (0,0)…(4,2), all level 0x20. `send_it` fires on the first `ready_to_send` after the last load.
- RAMP, frame 0 → levels (p,c): (0,0)=0, (0,1)=85, (0,2)=170, (1,0)=32, (4,2)=(128+170) mod 256=42. Frame 1: (0,0)=1.
- CHASE, base 0x10, over 6 frames → lit pixel cycles 0,1,2,3,4,0. Unlit slots load 0.
- `ready_to_load` toggled 1/0 every cycle in LOAD → still exactly 15 loads, correct order, no skipped or duplicated slot.
- `enable` dropped after 3 loads → frame completes (15 loads, 1 send). `frame_count` goes 0→1, then IDLE with `busy`=0.
- Reset asserted mid-LOAD and mid-GAP → outputs 0 at once. After release with `enable`=1, the next load is slot (0,0) and `frame_count`=0.
